// File: rtl/balu_pkg.sv
// Shared definitions for the iterative bit-manipulation unit: operation
// codes, FSM state encoding and the op-class helper.
package balu_pkg;

    localparam logic [7:0] MODE_BCLR = 8'h30;
    localparam logic [7:0] MODE_BEXT = 8'h31;
    localparam logic [7:0] MODE_BINV = 8'h32;
    localparam logic [7:0] MODE_BSET = 8'h33;
    localparam logic [7:0] MODE_CLZ  = 8'h34;
    localparam logic [7:0] MODE_CPOP = 8'h35;
    localparam logic [7:0] MODE_CTZ  = 8'h36;
    localparam logic [7:0] MODE_ROL  = 8'h37;
    localparam logic [7:0] MODE_ROR  = 8'h38;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Count ops are the only ones that take the multi-cycle CALC path.
    function automatic logic is_count_op(input logic [7:0] mode);
        return (mode == MODE_CLZ) || (mode == MODE_CTZ) || (mode == MODE_CPOP);
    endfunction

endpackage

// File: rtl/balu_iter_if.sv
// Request/response handshake bundle between the EX stage and the bit unit.
interface balu_iter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       mode_sel;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ans;
    logic             error;

    modport master (
        output in_valid, mode_sel, num1, num2, out_ready,
        input  in_ready, out_valid, ans, error
    );

    modport slave (
        input  in_valid, mode_sel, num1, num2, out_ready,
        output in_ready, out_valid, ans, error
    );
endinterface

// File: rtl/balu_chunk_cnt.sv
// Combinational per-chunk statistics: popcount, leading/trailing zeros and
// any-bit-set for one CHUNK-bit slice. An all-zero slice reports CHUNK zeros.
module balu_chunk_cnt #(
    parameter int  CHUNK = 4,
    localparam int CW    = $clog2(CHUNK) + 1
) (
    input  logic [CHUNK-1:0] d_i,
    output logic [CW-1:0]    pop_o,
    output logic [CW-1:0]    lz_o,
    output logic [CW-1:0]    tz_o,
    output logic             any_o
);

    // Last matching iteration wins: highest set bit for lz, lowest for tz.
    always_comb begin
        pop_o = '0;
        lz_o  = CW'(CHUNK);
        tz_o  = CW'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            if (d_i[i]) begin
                pop_o = pop_o + 1'b1;
                lz_o  = CW'(CHUNK - 1 - i);
            end
        end
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (d_i[i]) tz_o = CW'(i);
        end
        any_o = |d_i;
    end

endmodule

// File: rtl/balu_iter.sv
// Handshaked RV32B/RV64B bit unit. Single-bit ops and rotates finish at the
// accept edge; CLZ/CTZ/CPOP walk the operand CHUNK bits per cycle.
// Optional: define BALU_EARLY_EXIT_EN to let CLZ/CTZ finish on the first
// chunk that contains a set bit.
module balu_iter
    import balu_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  CHUNK = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input logic        clk,
    input logic        rstn,
    balu_iter_if.slave bus
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ACW  = $clog2(WIDTH) + 1;
    localparam int CCW  = $clog2(CHUNK) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [7:0]       mode_q, mode_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [ACW-1:0]   acc_q, acc_d;
    logic             seen_q, seen_d;
    logic [WIDTH-1:0] ans_q, ans_d;
    logic             err_q, err_d;

    // Chunk selection: CLZ walks from the MSB chunk, the others from the LSB.
    logic [NCH-1:0][CHUNK-1:0] chunks;
    logic [IDXW-1:0]           sel;
    logic [CCW-1:0]            c_pop, c_lz, c_tz, c_cnt;
    logic                      c_any;

    assign chunks = num_q;
    assign sel    = (mode_q == MODE_CLZ) ? IDXW'(NCH - 1) - idx_q : idx_q;

    balu_chunk_cnt #(.CHUNK(CHUNK)) u_cnt (
        .d_i   (chunks[sel]),
        .pop_o (c_pop),
        .lz_o  (c_lz),
        .tz_o  (c_tz),
        .any_o (c_any)
    );

    // Single-cycle datapath works straight off the request inputs.
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   mask;
    logic [2*WIDTH-1:0] dbl_l, dbl_r;
    logic               unused_num2;

    assign sh          = bus.num2[SHW-1:0];
    assign mask        = {{(WIDTH-1){1'b0}}, 1'b1} << sh;
    assign dbl_l       = {bus.num1, bus.num1} << sh;
    assign dbl_r       = {bus.num1, bus.num1} >> sh;
    assign unused_num2 = ^bus.num2[WIDTH-1:SHW];

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.ans       = ans_q;
    assign bus.error     = err_q;

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            num_q   <= '0;
            mode_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            seen_q  <= 1'b0;
            ans_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            seen_q  <= seen_d;
            ans_q   <= ans_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update.
    logic last;
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        seen_d  = seen_q;
        ans_d   = ans_q;
        err_d   = err_q;
        last    = 1'b0;
        c_cnt   = (mode_q == MODE_CPOP) ? c_pop :
                  (mode_q == MODE_CLZ)  ? c_lz  : c_tz;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    num_d  = bus.num1;
                    mode_d = bus.mode_sel;
                    idx_d  = '0;
                    acc_d  = '0;
                    seen_d = 1'b0;
                    err_d  = 1'b0;
                    if (is_count_op(bus.mode_sel)) begin
                        state_d = CALC;
                    end else begin
                        state_d = DONE;
                        case (bus.mode_sel)
                            MODE_BCLR: ans_d = bus.num1 & ~mask;
                            MODE_BEXT: ans_d = {{(WIDTH-1){1'b0}}, bus.num1[sh]};
                            MODE_BINV: ans_d = bus.num1 ^ mask;
                            MODE_BSET: ans_d = bus.num1 | mask;
                            MODE_ROL:  ans_d = dbl_l[2*WIDTH-1:WIDTH];
                            MODE_ROR:  ans_d = dbl_r[WIDTH-1:0];
                            default: begin
                                ans_d = '0;
                                err_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            CALC: begin
                // CLZ/CTZ freeze the count once a set bit has been passed.
                if (mode_q == MODE_CPOP || !seen_q) acc_d = acc_q + ACW'(c_cnt);
                seen_d = seen_q | c_any;
                idx_d  = idx_q + 1'b1;
                last   = (idx_q == IDXW'(NCH - 1));
`ifdef BALU_EARLY_EXIT_EN
                if (mode_q != MODE_CPOP && c_any) last = 1'b1;
`else
`endif
                if (last) begin
                    state_d = DONE;
                    ans_d   = WIDTH'(acc_d);
                    err_d   = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_balu_iter.sv
// Self-checking bench for balu_iter (WIDTH=32, CHUNK=4): directed test-plan
// cases, reset during CALC, then randomized ops against a bit-level model.
module tb_balu_iter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    balu_iter_if #(.WIDTH(32)) bif ();

    balu_iter #(.WIDTH(32), .CHUNK(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: result, error flag and edges from accept to out_valid.
    function automatic void ref_op(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e, output int lat);
        int s;
        int cnt;
        s   = int'(b % 32);
        r   = '0;
        e   = 1'b0;
        lat = 0;
        cnt = 0;
        case (m)
            8'h30: begin r = a; r[s] = 1'b0; end
            8'h31: r = {31'b0, a[s]};
            8'h32: begin r = a; r[s] = ~a[s]; end
            8'h33: begin r = a; r[s] = 1'b1; end
            8'h37: for (int i = 0; i < 32; i++) r[(i + s) % 32] = a[i];
            8'h38: for (int i = 0; i < 32; i++) r[i] = a[(i + s) % 32];
            8'h34: begin
                while (cnt < 32 && !a[31 - cnt]) cnt++;
                r = cnt; lat = 8;
`ifdef BALU_EARLY_EXIT_EN
                if (cnt < 32) lat = cnt / 4 + 1;
`endif
            end
            8'h36: begin
                while (cnt < 32 && !a[cnt]) cnt++;
                r = cnt; lat = 8;
`ifdef BALU_EARLY_EXIT_EN
                if (cnt < 32) lat = cnt / 4 + 1;
`endif
            end
            8'h35: begin
                for (int i = 0; i < 32; i++) cnt += int'(a[i]);
                r = cnt; lat = 8;
            end
            default: e = 1'b1;
        endcase
    endfunction

    // Issue one request, scramble inputs after acceptance, check latency and
    // result, optionally hold backpressure, then retire it.
    task automatic do_op(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
        logic [31:0] ea;
        logic        ee;
        int          el;
        int          n;
        ref_op(m, a, b, ea, ee, el);
        @(negedge clk);
        chk({tag, " in_ready"}, bif.in_ready, 1);
        bif.in_valid = 1'b1;
        bif.mode_sel = m;
        bif.num1     = a;
        bif.num2     = b;
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        bif.mode_sel = 8'($urandom);
        bif.num1     = $urandom;
        bif.num2     = $urandom;
        n = 0;
        while (!bif.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, n, el);
        chk({tag, " ans"}, bif.ans, ea);
        chk({tag, " error"}, bif.error, ee);
        for (int h = 0; h < hold; h++) begin
            bif.in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, " hold ans"}, bif.ans, ea);
            chk({tag, " hold err"}, bif.error, ee);
            chk({tag, " hold in_ready"}, bif.in_ready, 0);
            chk({tag, " hold out_valid"}, bif.out_valid, 1);
        end
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bif.out_ready = 1'b0;
        chk({tag, " retire out_valid"}, bif.out_valid, 0);
        chk({tag, " retire error"}, bif.error, 0);
        chk({tag, " retire in_ready"}, bif.in_ready, 1);
    endtask

    initial begin
        logic [7:0]  m;
        logic [31:0] a;
        bif.in_valid  = 1'b0;
        bif.mode_sel  = '0;
        bif.num1      = '0;
        bif.num2      = '0;
        bif.out_ready = 1'b0;

        #12;
        chk("reset out_valid", bif.out_valid, 0);
        chk("reset ans", bif.ans, 0);
        chk("reset error", bif.error, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post-reset in_ready", bif.in_ready, 1);

        do_op(8'h33, 32'h0000_0000, 32'd5, 0, "bset");
        do_op(8'h31, 32'h8000_0000, 32'd31, 0, "bext");
        do_op(8'h30, 32'hFFFF_FFFF, 32'd7, 0, "bclr");
        do_op(8'h32, 32'h0000_00F0, 32'd4, 0, "binv");
        do_op(8'h38, 32'h0000_0001, 32'd1, 0, "ror");
        do_op(8'h37, 32'h8000_0000, 32'd33, 0, "rol mod");
        do_op(8'h35, 32'hF0F0_0001, 32'd0, 0, "cpop");
        do_op(8'h34, 32'h0001_0000, 32'd0, 0, "clz");
        do_op(8'h36, 32'h0000_0000, 32'd0, 0, "ctz zero");
        do_op(8'h34, 32'h0000_0000, 32'd0, 0, "clz zero");
        do_op(8'h34, 32'h8000_0000, 32'd0, 0, "clz msb");
        do_op(8'h36, 32'h0000_0100, 32'd0, 0, "ctz 0x100");
        do_op(8'h33, 32'h1234_5678, 32'd0, 5, "backpressure");
        do_op(8'h3F, 32'hDEAD_BEEF, 32'd3, 0, "unknown");

        // Reset during CALC discards the in-flight count.
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.mode_sel = 8'h35;
        bif.num1     = 32'hF0F0_0001;
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("midreset out_valid", bif.out_valid, 0);
        chk("midreset ans", bif.ans, 0);
        chk("midreset error", bif.error, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("midreset in_ready", bif.in_ready, 1);
        do_op(8'h35, 32'hFFFF_FFFF, 32'd0, 0, "cpop ones");

        for (int i = 0; i < 30; i++) begin
            m = ($urandom_range(0, 9) == 9) ? 8'($urandom_range(8'h39, 8'hFF)) : 8'(8'h30 + $urandom_range(0, 8));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: a = a >> $urandom_range(0, 31);
                1: a = a << $urandom_range(0, 31);
                2: a = (a & 32'h0000_000F) << (4 * $urandom_range(0, 7));
                default: ;
            endcase
            do_op(m, a, $urandom, $urandom_range(0, 2), $sformatf("rand%0d m%0h", i, m));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
